// File: rtl/fl_pkg.sv
// fl_pkg: shared types, sizes and pointer arithmetic for the physical register free list.
package fl_pkg;
  localparam int NUM_PREGS = 128;
  localparam int NUM_AREGS = 32;
  localparam int ALLOC_WIDTH = 2;
  localparam int FREE_WIDTH = 2;
  localparam int PREG_W = $clog2(NUM_PREGS);
  localparam int DEPTH = NUM_PREGS - NUM_AREGS;
  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam logic [IDX_W:0] DEPTH_W = (IDX_W+1)'(DEPTH);
  typedef logic [PREG_W-1:0] preg_t;
  typedef struct packed {
    logic phase;
    logic [IDX_W-1:0] idx;
  } fl_ptr_t;
  // Index wraps modulo DEPTH so a non-power-of-2 depth works; phase flips on each wrap.
  function automatic fl_ptr_t ptr_add(fl_ptr_t p, logic [IDX_W:0] n);
    logic [IDX_W:0] s;
    fl_ptr_t r;
    s = {1'b0, p.idx} + n;
    r.phase = p.phase ^ (s >= DEPTH_W);
    r.idx = (s >= DEPTH_W) ? IDX_W'(s - DEPTH_W) : IDX_W'(s);
    return r;
  endfunction
  function automatic logic [IDX_W:0] ptr_count(fl_ptr_t t, fl_ptr_t h);
    return ({1'b0, t.idx} - {1'b0, h.idx}) + ((t.phase != h.phase) ? DEPTH_W : '0);
  endfunction
endpackage

// File: rtl/popcount_prefix.sv
// popcount_prefix: per-lane count of set bits below each lane, plus the total.
module popcount_prefix #(
  parameter int W = 2,
  localparam int CW = $clog2(W+1)
) (
  input  logic [W-1:0]         mask,
  output logic [W-1:0][CW-1:0] prefix,
  output logic [CW-1:0]        total
);
  logic [CW-1:0] acc;
  always_comb begin
    acc = '0;
    for (int i = 0; i < W; i++) begin
      prefix[i] = acc;
      acc = acc + CW'(mask[i]);
    end
    total = acc;
  end
endmodule

// File: rtl/free_preg_list.sv
// free_preg_list: multi-port circular free list of physical register tags with head checkpoint/restore.
module free_preg_list
  import fl_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic [ALLOC_WIDTH-1:0]        alloc_req,
  output logic                          alloc_ready,
  output logic [ALLOC_WIDTH*PREG_W-1:0] alloc_preg,
  input  logic [FREE_WIDTH-1:0]         free_valid,
  input  logic [FREE_WIDTH*PREG_W-1:0]  free_preg,
  output logic [PTR_W-1:0]              ckpt_head,
  input  logic                          recover_en,
  input  logic [PTR_W-1:0]              recover_head,
  output logic [IDX_W:0]                count,
  output logic                          empty,
  output logic                          full
);
  localparam int ACW = $clog2(ALLOC_WIDTH+1);
  localparam int FCW = $clog2(FREE_WIDTH+1);
  preg_t mem [DEPTH];
  fl_ptr_t head, tail;
  logic [ALLOC_WIDTH-1:0][ACW-1:0] a_pre;
  logic [ACW-1:0] a_tot;
  logic [FREE_WIDTH-1:0][FCW-1:0] f_pre;
  logic [FCW-1:0] f_tot;
  logic accept;
  popcount_prefix #(.W(ALLOC_WIDTH)) u_alloc_pc (.mask(alloc_req), .prefix(a_pre), .total(a_tot));
  popcount_prefix #(.W(FREE_WIDTH)) u_free_pc (.mask(free_valid), .prefix(f_pre), .total(f_tot));
  assign count = ptr_count(tail, head);
  assign alloc_ready = count >= (IDX_W+1)'(ALLOC_WIDTH);
  assign empty = count == '0;
  assign full = count == DEPTH_W;
  assign ckpt_head = head;
  assign accept = alloc_ready && |alloc_req && !recover_en;
  always_comb begin
    alloc_preg = '0;
    for (int i = 0; i < ALLOC_WIDTH; i++)
      alloc_preg[i*PREG_W +: PREG_W] = mem[ptr_add(head, (IDX_W+1)'(a_pre[i])).idx];
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      head <= '0;
      tail <= '{phase: 1'b1, idx: '0};
      for (int k = 0; k < DEPTH; k++) mem[k] <= PREG_W'(NUM_AREGS + k);
    end else begin
      head <= recover_en ? fl_ptr_t'(recover_head) : accept ? ptr_add(head, (IDX_W+1)'(a_tot)) : head;
      tail <= ptr_add(tail, (IDX_W+1)'(f_tot));
      for (int j = 0; j < FREE_WIDTH; j++)
        if (free_valid[j]) mem[ptr_add(tail, (IDX_W+1)'(f_pre[j])).idx] <= free_preg[j*PREG_W +: PREG_W];
    end
  end
  // Returning more tags than the list can hold means a duplicate release upstream.
  assert property (@(posedge clk) disable iff (!rst)
    recover_en || ({1'b0, count} + (IDX_W+2)'(f_tot) <= (IDX_W+2)'(DEPTH) + (IDX_W+2)'(accept ? a_tot : '0)));
endmodule

// File: doc/free_preg_list.md
Name: free_preg_list

Overview:
- Multi-port circular free list of physical register tags for the rename stage.
- Replaces the single-port free queue.
- Each cycle it hands out up to ALLOC_WIDTH free pregs to rename lanes and accepts up to FREE_WIDTH released pregs from commit.
- Exports a head-pointer checkpoint, and restores from one in a single cycle on branch-mispredict recovery.

Parameters:
- NUM_PREGS, 128, total physical registers; tag width PREG_W = $clog2(NUM_PREGS).
- NUM_AREGS, 32, architectural registers; pregs 0..NUM_AREGS-1 are architecturally mapped at reset.
- ALLOC_WIDTH, 2, rename allocate lanes (= `RENAME_WIDTH).
- FREE_WIDTH, 2, commit release lanes.
- Derived: DEPTH = NUM_PREGS-NUM_AREGS; IDX_W = $clog2(DEPTH); PTR_W = IDX_W+1 (MSB = wrap phase).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset.
- alloc_req  in  ALLOC_WIDTH  per-lane request mask.
- alloc_ready  out  1  list holds >= ALLOC_WIDTH entries; requests are accepted only when high.
- alloc_preg  out  ALLOC_WIDTH*PREG_W  granted tags; lane i in bits [i*PREG_W +: PREG_W].
- free_valid  in  FREE_WIDTH  per-lane release mask.
- free_preg  in  FREE_WIDTH*PREG_W  released tags.
- ckpt_head  out  PTR_W  current head pointer, sampled by rename for checkpoints.
- recover_en  in  1  restore head from recover_head.
- recover_head  in  PTR_W  checkpointed head.
- count  out  IDX_W+1  number of free entries.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.

Behaviour:
- Pointers: head/tail are {phase, idx}. idx increments modulo DEPTH (non-power-of-2 safe); phase toggles on wrap.
- count is derived as tail.idx - head.idx, plus DEPTH if the phases differ. full/empty are derived from it, never stored separately.
- Reset (rst==0 at posedge):
  - entry k = NUM_AREGS+k for k in 0..DEPTH-1;
  - head = 0; tail = {1'b1, 0} (full, count=DEPTH);
  - outputs: alloc_ready=1, count=DEPTH, full=1, empty=0, ckpt_head=0.
  - Reset mid-operation discards all state identically.
- Allocation is combinational read, first-word-fall-through:
  - lane i gets entry[(head.idx + r_i) mod DEPTH], where r_i = popcount(alloc_req[i-1:0]).
  - alloc_preg for non-requesting lanes is don't-care; the bench must not check it.
- Accept = alloc_ready && |alloc_req. On accept, head advances by popcount(alloc_req) at the posedge.
- alloc_ready = (count >= ALLOC_WIDTH), independent of the mask. This gives all-or-nothing stall for the whole rename group.
- Release:
  - valid free lanes are compacted in lane order;
  - entry[(tail.idx + j) mod DEPTH] = j-th valid tag;
  - tail advances by popcount(free_valid).
  - Free entries become allocatable the cycle after the write, never same-cycle bypassed.
- Simultaneous alloc+free: both apply; new count = count - nalloc + nfree.
- Recovery:
  - recover_en=1 sets head = recover_head; alloc_req is ignored that cycle.
  - Frees in the same cycle still apply to tail.
  - Entries between recover_head and old head are re-exposed, unchanged in storage.
- Overflow: a free that would make count > DEPTH is illegal. Add an assertion; RTL behaviour in that case is undefined.
- Duplicate tags are not detected.

Decomposition:
- Package fl_pkg:
  - preg_t (logic [PREG_W-1:0]);
  - fl_ptr_t struct {phase, idx};
  - functions ptr_add(ptr, n) (modulo-DEPTH with phase toggle) and ptr_count(tail, head).
- One sub-module: popcount_prefix. Given a mask, it produces per-lane prefix counts and the total. It is instantiated for both alloc_req and free_valid.

Test Plan:
- Reset: hold rst=0 two cycles, release -> count=96, full=1, alloc_ready=1, alloc_preg lanes = 32, 33.
- Sparse alloc: alloc_req=2'b10 -> lane1 gets 32; next cycle alloc_req=2'b11 -> lanes get 33, 34; count=93.
- Drain to stall: allocate 2/cycle for 47 cycles -> count=2, alloc_ready=1; one more -> count=0, empty=1, alloc_ready=0. Requests while empty -> head unchanged.
- Wrap and free: from empty, free_valid=2'b11 with tags 5, 9 -> next cycle count=2, alloc_preg = 5, 9. Verify head.idx wraps 95 -> 0 with phase toggle.
- Simultaneous: count=10, alloc 2 and free 1 (tag 40) same cycle -> count=9; tag 40 appears at the tail position.
- Recovery: capture ckpt_head=P, allocate 6 tags, then recover_en=1 with recover_head=P plus free tag 7 that cycle -> the same 6 tags reappear in order and count = pre-checkpoint count + 1.
